// File: rtl/id_ex_ctrl_pipe.sv
// RV32I(+M) ID-stage control decoder with a registered ID/EX control stage.
// Handles load-use bubbles, multi-cycle mul/div occupancy of EX, illegal-op flagging and flush.
module id_ex_ctrl_pipe #(
    parameter bit ENABLE_M   = 1'b1,
    parameter int DIV_CYCLES = 8,
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] instr,
    input  logic        ex_flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic        ex_jum,
    output logic        ex_jalr,
    output logic        ex_branch,
    output logic        ex_wen_rf,
    output logic        ex_alu_src,
    output logic        ex_en_dmem,
    output logic        ex_load_store,
    output logic [2:0]  ex_imm_sel,
    output logic [3:0]  ex_alu_ctrl,
    output logic [2:0]  ex_funct3,
    output logic [1:0]  ex_writeback,
    output logic        ex_muldiv,
    output logic        ex_illegal,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_S  = 3'd1;
    localparam logic [2:0] IMM_B  = 3'd2;
    localparam logic [2:0] IMM_SH = 3'd3;
    localparam logic [2:0] IMM_J  = 3'd4;
    localparam logic [2:0] IMM_U  = 3'd5;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_DMEM = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef struct packed {
        logic       valid;
        logic       jum;
        logic       jalr;
        logic       branch;
        logic       wen_rf;
        logic       alu_src;
        logic       en_dmem;
        logic       load_store;
        logic [2:0] imm_sel;
        logic [3:0] alu_ctrl;
        logic [2:0] funct3;
        logic [1:0] writeback;
        logic       muldiv;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    function automatic logic [3:0] alu_base(input logic [2:0] f3);
        logic [3:0] code;
        case (f3)
            3'b000:  code = ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    ctrl_t dec;
    logic  dec_illegal;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.valid   = 1'b1;
        dec.funct3  = funct3;
        dec.rd      = rd;
        dec.rs1     = (opcode == OPC_LUI) ? 5'd0 : rs1;
        dec.rs2     = rs2;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec.wen_rf   = 1'b1;
                dec.imm_sel  = IMM_U;
                dec.alu_src  = 1'b1;
                dec.alu_ctrl = ALU_ADD;
            end
            OPC_JAL: begin
                dec.jum       = 1'b1;
                dec.wen_rf    = 1'b1;
                dec.imm_sel   = IMM_J;
                dec.writeback = WB_PC4;
            end
            OPC_JALR: begin
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end else begin
                    dec.jalr      = 1'b1;
                    dec.wen_rf    = 1'b1;
                    dec.imm_sel   = IMM_I;
                    dec.alu_src   = 1'b1;
                    dec.alu_ctrl  = ALU_ADD;
                    dec.writeback = WB_PC4;
                end
            end
            OPC_BRANCH: begin
                dec.branch   = 1'b1;
                dec.imm_sel  = IMM_B;
                dec.alu_ctrl = ALU_SUB;
            end
            OPC_LOAD: begin
                dec.wen_rf    = 1'b1;
                dec.alu_src   = 1'b1;
                dec.en_dmem   = 1'b1;
                dec.writeback = WB_DMEM;
            end
            OPC_STORE: begin
                dec.imm_sel    = IMM_S;
                dec.alu_src    = 1'b1;
                dec.en_dmem    = 1'b1;
                dec.load_store = 1'b1;
            end
            OPC_OPIMM: begin
                dec.wen_rf   = 1'b1;
                dec.alu_src  = 1'b1;
                dec.alu_ctrl = alu_base(funct3);
                // Only the shift immediates reserve the upper bits as funct7.
                if (funct3 == 3'b001) begin
                    dec.imm_sel = IMM_SH;
                    if (funct7 != F7_BASE) dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec.imm_sel = IMM_SH;
                    if (funct7 == F7_ALT) begin
                        dec.alu_ctrl = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OPC_OP: begin
                case (funct7)
                    F7_BASE: begin
                        dec.wen_rf   = 1'b1;
                        dec.alu_ctrl = alu_base(funct3);
                    end
                    F7_ALT: begin
                        dec.wen_rf = 1'b1;
                        if (funct3 == 3'b000) begin
                            dec.alu_ctrl = ALU_SUB;
                        end else if (funct3 == 3'b101) begin
                            dec.alu_ctrl = ALU_SRA;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    F7_MEXT: begin
                        if (ENABLE_M) begin
                            dec.muldiv    = 1'b1;
                            dec.wen_rf    = 1'b1;
                            dec.alu_ctrl  = ALU_ADD;
                            dec.writeback = WB_ALU;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal op keeps its register fields for the trap handler but may not act.
        if (dec_illegal) begin
            dec.jum        = 1'b0;
            dec.jalr       = 1'b0;
            dec.branch     = 1'b0;
            dec.wen_rf     = 1'b0;
            dec.alu_src    = 1'b0;
            dec.en_dmem    = 1'b0;
            dec.load_store = 1'b0;
            dec.imm_sel    = 3'd0;
            dec.alu_ctrl   = 4'd0;
            dec.writeback  = 2'd0;
            dec.muldiv     = 1'b0;
            dec.illegal    = 1'b1;
        end
    end

    ctrl_t            ex_q;
    ctrl_t            ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             load_use;
    logic             busy;

    assign uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_JAL) || (opcode == OPC_AUIPC));
    assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);

    assign load_use = id_valid && ex_q.valid && ex_q.en_dmem && !ex_q.load_store &&
                      (ex_q.rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == ex_q.rd)) || (uses_rs2 && (rs2 == ex_q.rd)));

    assign busy     = (cnt_q != '0);
    assign id_stall = !ex_flush && (busy || load_use);

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (ex_flush) begin
            ex_d  = '0;
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (load_use || !id_valid) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
            if (dec.muldiv) begin
                cnt_d = dec.funct3[2] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_jum        = ex_q.jum;
    assign ex_jalr       = ex_q.jalr;
    assign ex_branch     = ex_q.branch;
    assign ex_wen_rf     = ex_q.wen_rf;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_en_dmem    = ex_q.en_dmem;
    assign ex_load_store = ex_q.load_store;
    assign ex_imm_sel    = ex_q.imm_sel;
    assign ex_alu_ctrl   = ex_q.alu_ctrl;
    assign ex_funct3     = ex_q.funct3;
    assign ex_writeback  = ex_q.writeback;
    assign ex_muldiv     = ex_q.muldiv;
    assign ex_illegal    = ex_q.illegal;
    assign ex_rd         = ex_q.rd;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: an M-enabled and an M-disabled instance share stimulus, each
// checked every cycle against a reference model through an expected-value queue.
module tb_id_ex_ctrl_pipe;

    typedef struct packed {
        logic       valid;
        logic       jum;
        logic       jalr;
        logic       branch;
        logic       wen;
        logic       alu_src;
        logic       en_dmem;
        logic       load_store;
        logic [2:0] imm_sel;
        logic [3:0] alu;
        logic [2:0] funct3;
        logic [1:0] wb;
        logic       muldiv;
        logic       illegal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_t;

    localparam int OBS_W = $bits(ex_t) + 1;
    localparam int DIV_C = 8;
    localparam int MUL_C = 2;

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_flush;
    logic [31:0] instr;

    logic        stall0, v0, jum0, jalr0, br0, wen0, asrc0, dmem0, ls0, md0, ill0;
    logic [2:0]  imm0, f30;
    logic [3:0]  alu0;
    logic [1:0]  wb0;
    logic [4:0]  rd0, rs10, rs20;
    logic        stall1, v1, jum1, jalr1, br1, wen1, asrc1, dmem1, ls1, md1, ill1;
    logic [2:0]  imm1, f31;
    logic [3:0]  alu1;
    logic [1:0]  wb1;
    logic [4:0]  rd1, rs11, rs21;

    always #5 clk = ~clk;

    id_ex_ctrl_pipe #(.ENABLE_M(1'b1), .DIV_CYCLES(DIV_C), .MUL_CYCLES(MUL_C)) u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .ex_flush(ex_flush),
        .id_stall(stall0), .ex_valid(v0), .ex_jum(jum0), .ex_jalr(jalr0), .ex_branch(br0),
        .ex_wen_rf(wen0), .ex_alu_src(asrc0), .ex_en_dmem(dmem0), .ex_load_store(ls0),
        .ex_imm_sel(imm0), .ex_alu_ctrl(alu0), .ex_funct3(f30), .ex_writeback(wb0),
        .ex_muldiv(md0), .ex_illegal(ill0), .ex_rd(rd0), .ex_rs1(rs10), .ex_rs2(rs20)
    );

    id_ex_ctrl_pipe #(.ENABLE_M(1'b0), .DIV_CYCLES(DIV_C), .MUL_CYCLES(MUL_C)) u_dut_nom (
        .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .ex_flush(ex_flush),
        .id_stall(stall1), .ex_valid(v1), .ex_jum(jum1), .ex_jalr(jalr1), .ex_branch(br1),
        .ex_wen_rf(wen1), .ex_alu_src(asrc1), .ex_en_dmem(dmem1), .ex_load_store(ls1),
        .ex_imm_sel(imm1), .ex_alu_ctrl(alu1), .ex_funct3(f31), .ex_writeback(wb1),
        .ex_muldiv(md1), .ex_illegal(ill1), .ex_rd(rd1), .ex_rs1(rs11), .ex_rs2(rs21)
    );

    logic [OBS_W-1:0] exp_q[$];
    logic [OBS_W-1:0] exp2_q[$];
    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model state: what EX holds and how many more cycles a mul/div keeps it.
    ex_t m_ex[2];
    int  m_busy[2];

    logic [3:0] alu_tab[8] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};

    function automatic ex_t ref_decode(input logic [31:0] w, input bit en_m);
        ex_t        e;
        ex_t        b;
        bit         bad;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = w[6:0];
        f7 = w[31:25];
        f3 = w[14:12];
        e = '0;
        bad = 1'b0;
        e.valid = 1'b1; e.funct3 = f3; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
        case (op)
            7'h37: begin e.wen = 1; e.imm_sel = 3'd5; e.alu_src = 1; e.rs1 = 5'd0; end
            7'h17: begin e.wen = 1; e.imm_sel = 3'd5; e.alu_src = 1; end
            7'h6F: begin e.jum = 1; e.wen = 1; e.imm_sel = 3'd4; e.wb = 2'd2; end
            7'h67: begin
                if (f3 == 3'd0) begin e.jalr = 1; e.wen = 1; e.alu_src = 1; e.wb = 2'd2; end
                else bad = 1'b1;
            end
            7'h63: begin e.branch = 1; e.imm_sel = 3'd2; e.alu = 4'd1; end
            7'h03: begin e.wen = 1; e.alu_src = 1; e.en_dmem = 1; e.wb = 2'd1; end
            7'h23: begin e.imm_sel = 3'd1; e.alu_src = 1; e.en_dmem = 1; e.load_store = 1; end
            7'h13: begin
                e.wen = 1; e.alu_src = 1; e.alu = alu_tab[f3];
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.imm_sel = 3'd3;
                    if (f3 == 3'd5 && f7 == 7'h20) e.alu = 4'd7;
                    else if (f7 != 7'h00) bad = 1'b1;
                end
            end
            7'h33: begin
                if (f7 == 7'h00) begin e.wen = 1; e.alu = alu_tab[f3]; end
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    e.wen = 1; e.alu = (f3 == 3'd0) ? 4'd1 : 4'd7;
                end
                else if (f7 == 7'h01 && en_m) begin e.muldiv = 1; e.wen = 1; end
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            b = '0;
            b.valid = 1; b.illegal = 1; b.funct3 = f3;
            b.rd = w[11:7]; b.rs1 = w[19:15]; b.rs2 = w[24:20];
            e = b;
        end
        return e;
    endfunction

    task automatic model_cycle(input int k, input bit en_m, input logic r, input logic v,
                               input logic [31:0] w, input logic f,
                               output logic [OBS_W-1:0] obs);
        ex_t        cur;
        ex_t        nxt;
        bit         hz;
        bit         stl;
        logic [6:0] op;
        cur = m_ex[k];
        op  = w[6:0];
        hz  = v && cur.valid && cur.en_dmem && !cur.load_store && cur.rd != 5'd0 &&
              ((!(op inside {7'h37, 7'h6F, 7'h17}) && w[19:15] == cur.rd) ||
               ((op inside {7'h33, 7'h63, 7'h23}) && w[24:20] == cur.rd));
        stl = !f && (m_busy[k] > 0 || hz);
        obs = {stl, cur};
        if (r || f) begin
            m_ex[k] = '0; m_busy[k] = 0;
        end else if (m_busy[k] > 0) begin
            m_busy[k] = m_busy[k] - 1;
        end else if (hz || !v) begin
            m_ex[k] = '0;
        end else begin
            nxt = ref_decode(w, en_m);
            m_ex[k] = nxt;
            m_busy[k] = nxt.muldiv ? (nxt.funct3[2] ? DIV_C - 1 : MUL_C - 1) : 0;
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] w, input logic f);
        logic [OBS_W-1:0] o0;
        logic [OBS_W-1:0] o1;
        rst = r; id_valid = v; instr = w; ex_flush = f;
        model_cycle(0, 1'b1, r, v, w, f, o0);
        model_cycle(1, 1'b0, r, v, w, f, o1);
        exp_q.push_back(o0);
        exp2_q.push_back(o1);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [OBS_W-1:0] a, input logic [OBS_W-1:0] e);
        chk_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, a, e);
    endtask

    logic [OBS_W-1:0] e0, e1;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            e0 = exp_q.pop_front();
            check("m_on", {stall0, v0, jum0, jalr0, br0, wen0, asrc0, dmem0, ls0, imm0, alu0,
                           f30, wb0, md0, ill0, rd0, rs10, rs20}, e0);
        end
        if (exp2_q.size() != 0) begin
            e1 = exp2_q.pop_front();
            check("m_off", {stall1, v1, jum1, jalr1, br1, wen1, asrc1, dmem1, ls1, imm1, alu1,
                            f31, wb1, md1, ill1, rd1, rs11, rs21}, e1);
        end
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [19:0] upper;
        rd    = 5'($urandom_range(0, 3));
        rs1   = 5'($urandom_range(0, 3));
        rs2   = 5'($urandom_range(0, 3));
        f3    = 3'($urandom_range(0, 7));
        imm   = 12'($urandom);
        upper = 20'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 9))
            0: return {f7, rs2, rs1, f3, rd, 7'h33};
            1: return {f7, rs2, rs1, f3, rd, 7'h13};
            2: return {imm, rs1, f3, rd, 7'h03};
            3: return {f7, rs2, rs1, f3, rd, 7'h23};
            4: return {f7, rs2, rs1, f3, rd, 7'h63};
            5: return {upper, rd, 7'h6F};
            6: return {imm, rs1, ($urandom_range(0, 3) == 0) ? f3 : 3'd0, rd, 7'h67};
            7: return {upper, rd, 7'h37};
            8: return {upper, rd, 7'h17};
            default: return $urandom;
        endcase
    endfunction

    localparam logic [31:0] ADDI_X1 = 32'h0050_0093;
    localparam logic [31:0] LW_X2   = 32'h0000_A103;
    localparam logic [31:0] ADD_X3  = 32'h0011_01B3;
    localparam logic [31:0] LW_X0   = 32'h0000_A003;
    localparam logic [31:0] ADD_X0S = 32'h0010_01B3;
    localparam logic [31:0] DIV_X4  = 32'h0262_C233;
    localparam logic [31:0] MUL_X1  = 32'h0231_00B3;
    localparam logic [31:0] JAL_X1  = 32'h0080_00EF;
    localparam logic [31:0] JALR_X0 = 32'h0000_8067;
    localparam logic [31:0] BAD_OPC = 32'h0000_007F;

    initial begin
        rst = 1'b1; id_valid = 1'b0; instr = '0; ex_flush = 1'b0;
        for (int k = 0; k < 2; k++) begin m_ex[k] = '0; m_busy[k] = 0; end
        @(posedge clk);
        #1;
        drive(1, 0, 32'd0, 0);
        drive(0, 1, ADDI_X1, 0);
        drive(0, 0, 32'd0, 0);
        // Load-use on x2, then the same pair with rd=x0.
        drive(0, 1, LW_X2, 0);
        drive(0, 1, ADD_X3, 0);
        drive(0, 1, ADD_X3, 0);
        drive(0, 1, LW_X0, 0);
        drive(0, 1, ADD_X0S, 0);
        drive(0, 0, 32'd0, 0);
        // Full-length divide followed by a waiting addi.
        drive(0, 1, DIV_X4, 0);
        repeat (9) drive(0, 1, ADDI_X1, 0);
        drive(0, 0, 32'd0, 0);
        // Divide killed by a flush in its third EX cycle.
        drive(0, 1, DIV_X4, 0);
        drive(0, 1, ADDI_X1, 0);
        drive(0, 1, ADDI_X1, 0);
        drive(0, 1, ADDI_X1, 1);
        drive(0, 0, 32'd0, 0);
        drive(0, 1, JAL_X1, 0);
        drive(0, 1, JALR_X0, 0);
        drive(0, 1, BAD_OPC, 0);
        drive(0, 1, MUL_X1, 0);
        drive(0, 1, ADDI_X1, 0);
        drive(0, 1, ADDI_X1, 0);
        // Reset in the middle of a divide stall.
        drive(0, 1, DIV_X4, 0);
        drive(0, 1, ADDI_X1, 0);
        drive(1, 1, ADDI_X1, 0);
        drive(0, 0, 32'd0, 0);
        for (int i = 0; i < 1500; i++) begin
            drive(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 9) != 0),
                  rand_instr(), logic'($urandom_range(0, 11) == 0));
        end
        drive(0, 0, 32'd0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
